tick_scan_gen: RTL and testbench
================================

TICK_SCAN_GEN -- requirements
Module: tick_scan_gen

Interface
REQ-001 Parameter DIV_W, default 27, width of the divide counter and divisor values.
REQ-002 Parameter DIV_DEFAULT, default 100000000, divisor loaded at reset; must fit in DIV_W bits.
REQ-003 Parameter SCAN_N, default 4, number of scan slots (display digits) per frame; legal range 2..256.
REQ-004 Parameter SCAN_W, default 2, width of scan_idx; must hold SCAN_N-1.
REQ-005 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-006 Port: reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 Port: en  input  1  run enable; 1 = divider counts, 0 = divider holds.
REQ-008 Port: div_ld  input  1  one-cycle request to load div_val as the new divisor.
REQ-009 Port: div_val  input  DIV_W  requested divisor (clk cycles per tick).
REQ-010 Port: tick  output  1  one-clk-wide pulse once per divisor period (counter/stopwatch enable).
REQ-011 Port: scan_idx  output  SCAN_W  active scan slot, 0..SCAN_N-1.
REQ-012 Port: frame  output  1  one-clk-wide pulse when scan_idx wraps to 0.
REQ-013 Port: div_cur  output  DIV_W  divisor currently in effect.
REQ-014 Port (only with TSG_CLR_EN): clr  input  1  synchronous restart request.

Function
REQ-015 Internal counter cnt (DIV_W bits) shall count 0..div_cur-1 while en=1, advancing by 1 per clk.
REQ-016 tick shall be a registered output, asserted for exactly the cycle following the edge on which cnt==div_cur-1 with en=1; cnt returns to 0 on that same edge.
REQ-017 With en=0, cnt, scan_idx and the pending divisor shall hold, and tick and frame shall be 0.
REQ-018 A divisor of 0 or 1 (loaded or default) shall be treated as 1: tick asserted every enabled cycle.
REQ-019 div_ld=1 shall capture div_val into a pending register and set a pending flag; a second div_ld before application overwrites the pending value.
REQ-020 A pending divisor shall become div_cur only on the edge where the current period ends (terminal count with en=1); the new period then starts from cnt=0 with the new value.
REQ-021 div_ld coincident with a terminal-count edge shall apply the newly captured div_val on that same edge.
REQ-022 If en=0 when div_ld arrives, the load stays pending until the next terminal count after en returns.
REQ-023 scan_idx shall increment by 1 on each edge that generates a tick, wrapping from SCAN_N-1 to 0.
REQ-024 frame shall be asserted in the same cycle as the tick whose generating edge wrapped scan_idx to 0.
REQ-025 tick, frame and scan_idx shall be glitch-free registered outputs; none is used as a clock.

Reset
REQ-026 On reset=0 at a clk edge: cnt=0, scan_idx=0, tick=0, frame=0, div_cur=DIV_DEFAULT, pending flag cleared; takes priority over en, div_ld and clr.
REQ-027 Reset asserted mid-period shall discard the partial count and any pending load; first tick after release occurs DIV_DEFAULT enabled cycles later.

Configuration
REQ-028 Macro TSG_CLR_EN defined: clr port exists; clr=1 (with reset=1) sets cnt=0, scan_idx=0, tick=0, frame=0 on that edge, preserves div_cur, and applies any pending divisor immediately; clr has priority over en and terminal count.
REQ-029 Macro TSG_CLR_EN undefined: no clr port and no restart logic; behaviour otherwise identical.

Verification
REQ-030 DIV_DEFAULT=4, SCAN_N=4, en=1 after reset release -> tick pulses on cycles 4,8,12,16 after release; scan_idx 1,2,3,0; frame only with the 4th tick.
REQ-031 DIV_DEFAULT=4, en dropped for 3 cycles mid-period at cnt=2 -> next tick delayed by exactly 3 cycles; no tick/frame while en=0.
REQ-032 div_ld with div_val=6 at cnt=1 of a 4-period -> current period still ends at 4 cycles; following ticks spaced 6 cycles; div_cur=6 from the switch edge.
REQ-033 div_val=0 loaded -> after current period, tick high every enabled cycle, scan_idx advancing every cycle, frame every 4th cycle.
REQ-034 reset=0 for one edge at cnt=3 with pending load of 8 -> div_cur=DIV_DEFAULT, pending dropped, outputs zero, next tick DIV_DEFAULT cycles later.
REQ-035 TSG_CLR_EN defined, clr pulse at scan_idx=2, cnt=2 -> scan_idx=0, cnt=0, div_cur unchanged, next tick div_cur cycles later.

Source files
------------

// File: rtl/tick_scan_gen.sv
// tick_scan_gen: programmable tick divider with a display-scan slot counter.
// A divide counter produces a one-cycle tick every div_cur enabled cycles,
// and each tick advances scan_idx through SCAN_N slots, pulsing frame on wrap.
// New divisors are queued and only take effect at the end of a period.
// Optional feature: define TSG_CLR_EN to add the synchronous clr restart input.
module tick_scan_gen #(
  parameter int          DIV_W       = 27,
  parameter int unsigned DIV_DEFAULT = 100000000,
  parameter int          SCAN_N      = 4,
  parameter int          SCAN_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              div_ld,
  input  logic [DIV_W-1:0]  div_val,
`ifdef TSG_CLR_EN
  input  logic              clr,
`endif
  output logic              tick,
  output logic [SCAN_W-1:0] scan_idx,
  output logic              frame,
  output logic [DIV_W-1:0]  div_cur
);

  localparam logic [DIV_W-1:0]  DIV_INIT  = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_N - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_cur_q, div_cur_d;
  logic [DIV_W-1:0]  pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              tick_q, tick_d;
  logic              frame_q, frame_d;

  logic [DIV_W-1:0]  effDiv;
  logic              termCnt;

  // Divisors of 0 and 1 both mean "tick every enabled cycle"; terminal count
  // uses >= so the counter can never run past the end of a period.
  always_comb begin
    effDiv  = (div_cur_q <= DIV_ONE) ? DIV_ONE : div_cur_q;
    termCnt = en && (cnt_q >= (effDiv - DIV_ONE));
  end

  // Next-state logic for the counter, scan slot, divisor queue and pulses.
  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    scan_d     = scan_q;
    tick_d     = 1'b0;
    frame_d    = 1'b0;

    if (en) begin
      if (termCnt) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        frame_d = (scan_q == SCAN_LAST);
        scan_d  = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_ONE;
      end else begin
        cnt_d = cnt_q + DIV_ONE;
      end
    end

    if (div_ld && termCnt) begin
      div_cur_d  = div_val;
      pend_vld_d = 1'b0;
    end else if (div_ld) begin
      pend_d     = div_val;
      pend_vld_d = 1'b1;
    end else if (termCnt && pend_vld_q) begin
      div_cur_d  = pend_q;
      pend_vld_d = 1'b0;
    end

`ifdef TSG_CLR_EN
    if (clr) begin
      cnt_d   = '0;
      scan_d  = '0;
      tick_d  = 1'b0;
      frame_d = 1'b0;
      if (div_ld) begin
        div_cur_d  = div_val;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        div_cur_d  = pend_q;
        pend_vld_d = 1'b0;
      end
    end
`endif
  end

  // State registers with synchronous active-low reset to the default divisor.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      div_cur_q  <= DIV_INIT;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      scan_q     <= '0;
      tick_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      scan_q     <= scan_d;
      tick_q     <= tick_d;
      frame_q    <= frame_d;
    end
  end

  assign tick     = tick_q;
  assign frame    = frame_q;
  assign scan_idx = scan_q;
  assign div_cur  = div_cur_q;

endmodule

// File: tb/tb_tick_scan_gen.sv
// Testbench for tick_scan_gen with DIV_DEFAULT=4, SCAN_N=4.
// Vectors carry stimulus plus expected outputs; expectations are queued when
// stimulus is driven and compared one cycle later after the clock edge.
module tb_tick_scan_gen;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          div_ld = 1'b0;
  logic [DW-1:0] div_val = '0;
  logic          tick;
  logic          frame;
  logic [1:0]    scan_idx;
  logic [DW-1:0] div_cur;
`ifdef TSG_CLR_EN
  logic          clr = 1'b0;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int vecNum = 0;

  typedef struct {
    logic          rst;
    logic          clrReq;
    logic          en;
    logic          ld;
    logic [DW-1:0] val;
    logic          tick;
    logic [1:0]    scan;
    logic          frame;
    logic          chkDiv;
    logic [DW-1:0] divc;
  } vec_t;

  vec_t expQ[$];
  vec_t tbl[$];

  tick_scan_gen #(
    .DIV_W(DW),
    .DIV_DEFAULT(4),
    .SCAN_N(4),
    .SCAN_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .div_ld(div_ld),
    .div_val(div_val),
`ifdef TSG_CLR_EN
    .clr(clr),
`endif
    .tick(tick),
    .scan_idx(scan_idx),
    .frame(frame),
    .div_cur(div_cur)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic rst, input logic clrReq, input logic e,
                              input logic ld, input logic [DW-1:0] val,
                              input logic t, input logic [1:0] s, input logic f,
                              input logic chkDiv, input logic [DW-1:0] divc);
    vec_t r;
    r.rst = rst; r.clrReq = clrReq; r.en = e; r.ld = ld; r.val = val;
    r.tick = t; r.scan = s; r.frame = f; r.chkDiv = chkDiv; r.divc = divc;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL vec %0d %s: got %0h expected %0h", vecNum, name, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL vec %0d scoreboard: got empty queue expected an entry", vecNum);
    end else begin
      e = expQ.pop_front();
      cmp("tick", 32'(tick), 32'(e.tick));
      cmp("scan_idx", 32'(scan_idx), 32'(e.scan));
      cmp("frame", 32'(frame), 32'(e.frame));
      if (e.chkDiv) cmp("div_cur", 32'(div_cur), 32'(e.divc));
    end
    vecNum++;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset   = ~v.rst;
    en      = v.en;
    div_ld  = v.ld;
    div_val = v.val;
`ifdef TSG_CLR_EN
    clr     = v.clrReq;
`endif
    expQ.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset state, then free-running ticks with DIV_DEFAULT=4.
    tbl.push_back(mk(1,0,0,0,0, 0,2'd0,0, 1,8'd4));
    tbl.push_back(mk(1,0,1,0,0, 0,2'd0,0, 1,8'd4));
    for (int i = 1; i <= 16; i++)
      tbl.push_back(mk(0,0,1,0,0, (i % 4) == 0, 2'((i / 4) % 4), i == 16, 1, 8'd4));

    // en dropped for 3 cycles at cnt=2 delays the next tick by 3 cycles.
    tbl.push_back(mk(0,0,1,0,0, 0,2'd0,0, 1,8'd4));
    tbl.push_back(mk(0,0,1,0,0, 0,2'd0,0, 1,8'd4));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,0,0, 0,2'd0,0, 1,8'd4));
    tbl.push_back(mk(0,0,1,0,0, 0,2'd0,0, 1,8'd4));
    tbl.push_back(mk(0,0,1,0,0, 1,2'd1,0, 1,8'd4));

    // div_ld of 6 at cnt=1: current period still 4, then 6-cycle spacing.
    tbl.push_back(mk(0,0,1,0,0,    0,2'd1,0, 1,8'd4));
    tbl.push_back(mk(0,0,1,1,8'd6, 0,2'd1,0, 1,8'd4));
    tbl.push_back(mk(0,0,1,0,0,    0,2'd1,0, 1,8'd4));
    tbl.push_back(mk(0,0,1,0,0,    1,2'd2,0, 1,8'd6));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,1,0,0, 0,2'd2,0, 1,8'd6));
    tbl.push_back(mk(0,0,1,0,0, 1,2'd3,0, 1,8'd6));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,1,0,0, 0,2'd3,0, 1,8'd6));
    tbl.push_back(mk(0,0,1,0,0, 1,2'd0,1, 1,8'd6));

    // Divisor 0 loaded: current 6-period finishes, then a tick every cycle.
    tbl.push_back(mk(0,0,1,1,8'd0, 0,2'd0,0, 1,8'd6));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,1,0,0, 0,2'd0,0, 1,8'd6));
    tbl.push_back(mk(0,0,1,0,0, 1,2'd1,0, 0,8'd0));
    for (int i = 2; i <= 8; i++)
      tbl.push_back(mk(0,0,1,0,0, 1,2'(i % 4), (i % 4) == 0, 0, 8'd0));

    $display("[TB] applying %0d table vectors", tbl.size());
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    // Load coincident with terminal count applies at once; then reset at
    // cnt=3 with a pending 8 must drop it and restore the default period.
    applyStimulus(mk(0,0,1,1,8'd4, 1,2'd1,0, 1,8'd4));
    applyStimulus(mk(0,0,1,0,0,    0,2'd1,0, 1,8'd4));
    applyStimulus(mk(0,0,1,1,8'd8, 0,2'd1,0, 1,8'd4));
    applyStimulus(mk(0,0,1,0,0,    0,2'd1,0, 1,8'd4));
    applyStimulus(mk(1,0,1,0,0,    0,2'd0,0, 1,8'd4));
    for (int i = 0; i < 3; i++) applyStimulus(mk(0,0,1,0,0, 0,2'd0,0, 1,8'd4));
    applyStimulus(mk(0,0,1,0,0, 1,2'd1,0, 1,8'd4));
    for (int i = 0; i < 3; i++) applyStimulus(mk(0,0,1,0,0, 0,2'd1,0, 1,8'd4));
    applyStimulus(mk(0,0,1,0,0, 1,2'd2,0, 1,8'd4));

`ifdef TSG_CLR_EN
    // clr at scan_idx=2, cnt=2 restarts the period and the scan sequence.
    applyStimulus(mk(0,0,1,0,0, 0,2'd2,0, 1,8'd4));
    applyStimulus(mk(0,0,1,0,0, 0,2'd2,0, 1,8'd4));
    applyStimulus(mk(0,1,1,0,0, 0,2'd0,0, 1,8'd4));
    for (int i = 0; i < 3; i++) applyStimulus(mk(0,0,1,0,0, 0,2'd0,0, 1,8'd4));
    applyStimulus(mk(0,0,1,0,0, 1,2'd1,0, 1,8'd4));
`endif

    cmp("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
